// File: rtl/core_pkg.sv
// Core-wide configuration shared by the execution units.
package core_pkg;

    localparam int unsigned DATA_WIDTH = 32;

endpackage

// File: rtl/div_pkg.sv
// Types and special-case result fills for the sequential divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

    // Fill bits replicated to DATA_WIDTH: quotient of x/0 is all-ones,
    // remainder of MIN/-1 is zero.
    localparam logic DIVZ_QUOT_FILL = 1'b1;
    localparam logic OVF_REM_FILL   = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, emit quotient bit.
module div_step #(
    parameter int unsigned DATA_WIDTH = core_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] quo_o
);

    logic [DATA_WIDTH:0] partial;
    logic [DATA_WIDTH:0] diff;
    logic                q_bit;

    // quo_i holds the not-yet-consumed dividend bits on top and the
    // quotient bits produced so far at the bottom.
    always_comb begin
        partial = {rem_i, quo_i[DATA_WIDTH-1]};
        diff    = partial - {1'b0, divisor_i};
        q_bit   = ~diff[DATA_WIDTH];
        rem_o   = q_bit ? diff[DATA_WIDTH-1:0] : partial[DATA_WIDTH-1:0];
        quo_o   = {quo_i[DATA_WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for DIV/DIVU/REM/REMU with a valid/ready handoff to MEM.
module div_seq
    import div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = core_pkg::DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  flush_i,
    input  logic                  mem_ready_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    div_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  is_rem_q, is_rem_d;
    logic                  neg_q, neg_d;

    logic [DATA_WIDTH-1:0] step_rem, step_quo;
    logic [DATA_WIDTH-1:0] a_abs, b_abs, min_neg;
    logic [DATA_WIDTH-1:0] quo_fix, rem_fix;
    div_op_t               op;
    logic                  signed_op, is_rem_op, a_neg, b_neg, overflow;
    logic                  ready_int, busy_int, valid_int;

    div_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_div_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(divisor_q),
        .rem_o    (step_rem),
        .quo_o    (step_quo)
    );

    always_comb begin
        op        = div_op_t'(op_i);
        signed_op = (op == DIV) || (op == REM);
        is_rem_op = (op == REM) || (op == REMU);
        a_neg     = signed_op && dividend_i[DATA_WIDTH-1];
        b_neg     = signed_op && divisor_i[DATA_WIDTH-1];
        a_abs     = a_neg ? ('0 - dividend_i) : dividend_i;
        b_abs     = b_neg ? ('0 - divisor_i) : divisor_i;
        min_neg   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        overflow  = signed_op && (dividend_i == min_neg) && (divisor_i == '1);
        // neg_q already folds in the op: remainder follows the dividend, quotient the sign xor
        quo_fix   = neg_q ? ('0 - step_quo) : step_quo;
        rem_fix   = neg_q ? ('0 - step_rem) : step_rem;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        divisor_d = divisor_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        res_d     = res_q;
        is_rem_d  = is_rem_q;
        neg_d     = neg_q;
        ready_int = 1'b0;
        busy_int  = 1'b0;
        valid_int = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready_int = 1'b1;
                if (start_i && !flush_i) begin
                    is_rem_d = is_rem_op;
                    if (divisor_i == '0) begin
                        res_d   = is_rem_op ? dividend_i : {DATA_WIDTH{DIVZ_QUOT_FILL}};
                        state_d = DONE;
                    end else if (overflow) begin
                        res_d   = is_rem_op ? {DATA_WIDTH{OVF_REM_FILL}} : dividend_i;
                        state_d = DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = a_abs;
                        divisor_d = b_abs;
                        neg_d     = is_rem_op ? a_neg : (a_neg ^ b_neg);
                        cnt_d     = CNT_LAST;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                busy_int = 1'b1;
                rem_d    = step_rem;
                quo_d    = step_quo;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    res_d   = is_rem_q ? rem_fix : quo_fix;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_int  = 1'b1;
                valid_int = 1'b1;
                if (mem_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush_i) begin
            state_d = IDLE;
        end
    end

    // Outputs are gated by rstn_i so they drop in the same cycle reset asserts.
    assign ready_o  = rstn_i && ready_int;
    assign busy_o   = rstn_i && busy_int;
    assign valid_o  = rstn_i && valid_int;
    assign result_o = valid_o ? res_q : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            res_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            divisor_q <= divisor_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            res_q     <= res_d;
            is_rem_q  <= is_rem_d;
            neg_q     <= neg_d;
        end
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default core_pkg::DATA_WIDTH (32), operand/result width in bits.
REQ-002 SHALL have port clk_i  input  1  system clock; single clock domain, all state updates on its rising edge.
REQ-003 SHALL have port rstn_i  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  EXE presents a divide/remainder uop.
REQ-005 SHALL have port op_i  input  2  operation, div_op_t.
REQ-006 SHALL have port dividend_i  input  DATA_WIDTH  op1.
REQ-007 SHALL have port divisor_i  input  DATA_WIDTH  op2.
REQ-008 SHALL have port flush_i  input  1  pipeline controller kill of the in-flight uop.
REQ-009 SHALL have port mem_ready_i  input  1  MEM accepts the result.
REQ-010 SHALL have port ready_o  output  1  can accept a new uop.
REQ-011 SHALL have port busy_o  output  1  uop in flight; EXE stalls on it.
REQ-012 SHALL have port valid_o  output  1  result_o valid.
REQ-013 SHALL have port result_o  output  DATA_WIDTH  quotient or remainder.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and DONE.
REQ-015 IDLE outputs SHALL be ready_o=1, busy_o=0, valid_o=0; start_i && ready_o sampled at an edge captures op_i and the operands.
REQ-016 On accept with divisor_i==0, the FSM SHALL go to DONE; the result is all-ones for DIV/DIVU, dividend for REM/REMU.
REQ-017 On accept of a signed op with dividend == 2^(DATA_WIDTH-1) and divisor == all-ones, the FSM SHALL go to DONE; the result is the dividend for DIV, 0 for REM.
REQ-018 Any other accept SHALL load the absolute values (signed ops) or raw values (unsigned ops), load the iteration counter with DATA_WIDTH-1 and go to CALC.
REQ-019 CALC SHALL perform one restoring-division step per cycle, producing one quotient bit MSB first, and decrement the counter.
REQ-020 At counter==0, CALC SHALL go to DONE; CALC lasts exactly DATA_WIDTH cycles.
REQ-021 Latency SHALL be as follows, with the accept sampled at the end of cycle k:
- normal: valid_o first high in cycle k+DATA_WIDTH+1
- special cases (REQ-016/017): valid_o first high in cycle k+1
REQ-022 Sign correction SHALL negate the quotient when operand signs differ (DIV), and give the remainder the sign of the dividend (REM); unsigned ops are uncorrected.
REQ-023 DONE SHALL drive valid_o=1, busy_o=1 and ready_o=0.
REQ-024 result_o SHALL stay stable until valid_o && mem_ready_i; the FSM then goes to IDLE. Back-to-back accept in the DONE cycle is not allowed.
REQ-025 result_o SHALL be 0 whenever valid_o=0.
REQ-026 busy_o SHALL be 1 in CALC and DONE.
REQ-027 flush_i SHALL force IDLE at the next edge from any state; flush_i has priority over start_i and mem_ready_i, and no valid_o follows a flushed uop.
REQ-028 start_i SHALL be ignored in CALC and DONE; operand inputs may change after accept without effect.

Reset
REQ-029 rstn_i low SHALL immediately force state IDLE and clear counter, operand, quotient and remainder registers.
REQ-030 While rstn_i is low, ready_o, busy_o and valid_o SHALL be 0 and result_o SHALL be 0.
REQ-031 Reset asserted mid-CALC or mid-DONE SHALL abort the uop; no valid_o pulse after release.
REQ-032 ready_o SHALL rise in the first cycle after rstn_i release.

Structure
REQ-033 Package div_pkg SHALL hold:
- div_op_t: DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11
- div_state_t
- the special-case result constants
REQ-034 DATA_WIDTH SHALL be imported from core_pkg.
REQ-035 One combinational sub-module, div_step, SHALL implement a single restoring iteration: shift, trial subtract, quotient bit. div_seq SHALL hold the FSM, counter and registers.

Verification
REQ-036 Bench SHALL cover: DIVU 100/7 accepted cycle k -> result_o=14, valid_o first in cycle k+33; REMU same operands -> 2.
REQ-037 Bench SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD.
REQ-038 Bench SHALL cover: DIV 5/0 -> 0xFFFFFFFF in cycle k+1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-039 Bench SHALL cover: mem_ready_i low for 5 cycles in DONE -> valid_o and result_o held for 5 cycles; IDLE and ready_o=1 the cycle after mem_ready_i rises.
REQ-040 Bench SHALL cover: flush_i on cycle 10 of CALC together with start_i -> ready_o=1 next cycle, no valid_o; a following DIVU 9/3 -> 3.
REQ-041 Bench SHALL cover: rstn_i pulsed low mid-CALC -> outputs 0 immediately, ready_o=1 after release, no stale valid_o.
